dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 118 +++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Wait-state data memory slave: captures one load/store request, optionally stalls
// WAIT_CYCLES cycles, then performs the access and pulses MemReady for one cycle.
module dmem_responder #(
   parameter int DEPTH_LOG2  = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReq,
   input  logic        MemWrite,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        MemReady,
   output logic        AddrErr
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam int         NWORDS = 1 << DEPTH_LOG2;

   logic [1:0]            state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  wr_q, wr_d;
   logic                  err_q, err_d;
   logic [DEPTH_LOG2-1:0] idx_q, idx_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           rdata_q, rdata_d;
   logic [31:0]           mem_q [NWORDS];

   logic                  req_err;
   logic                  acc;
   logic                  acc_wr;
   logic [DEPTH_LOG2-1:0] acc_idx;
   logic [31:0]           acc_data;

   assign req_err = (Addr[1:0] != 2'b00) || ({2'b00, Addr[31:2]} >= 32'(NWORDS));

   // The access fires on the edge entering RESP; with no wait states that edge is
   // the capture edge itself, so the live inputs are used instead of the registers.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wr_d     = wr_q;
      err_d    = err_q;
      idx_d    = idx_q;
      wdata_d  = wdata_q;
      acc      = 1'b0;
      acc_wr   = wr_q;
      acc_idx  = idx_q;
      acc_data = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (MemReq) begin
               wr_d     = MemWrite;
               idx_d    = Addr[DEPTH_LOG2+1:2];
               wdata_d  = WriteData;
               err_d    = req_err;
               acc_wr   = MemWrite;
               acc_idx  = Addr[DEPTH_LOG2+1:2];
               acc_data = WriteData;
               if (req_err) begin
                  state_d = S_RESP;
               end else if (WAIT_CYCLES == 0) begin
                  state_d = S_RESP;
                  acc     = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = 4'(WAIT_CYCLES - 1);
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_RESP;
               acc     = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      rdata_d = rdata_q;
      if (acc && !acc_wr) rdata_d = mem_q[acc_idx];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         err_q   <= err_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Array is not reset; reset only blocks a store landing on the same edge.
   always_ff @(posedge clk) begin
      if (!reset && acc && acc_wr) mem_q[acc_idx] <= acc_data;
   end

   assign MemReady = (state_q == S_RESP);
   assign AddrErr  = (state_q == S_RESP) && err_q;
   assign ReadData = rdata_q;

endmodule
